// File: rtl/uart_in_fifo.sv
// Receive buffer between uart_rx and the IN instruction: byte or packed-word FIFO
// with occupancy count, sticky overflow/framing flags and a one-cycle read pulse.
module uart_in_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 14,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_ferr,
  input  logic                  mode,
  input  logic                  rd_req,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  ferr_seen,
  input  logic                  flag_clr
);

  localparam int unsigned WB    = DATA_W / 8;
  localparam int unsigned IDX_W = (WB > 1) ? $clog2(WB) : 1;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH    = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WB - 1);

  logic [DATA_W-1:0]     mem [0:(1 << DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_W-1:0]     part_q, part_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_base;
  logic                  mode_q;
  logic [DATA_W-1:0]     rd_data_q;
  logic                  rd_valid_q;
  logic                  overflow_q, overflow_d;
  logic                  ferr_q, ferr_d;

  logic                  byte_ok, byte_bad;
  logic [DATA_W-1:0]     word_cur, push_word;
  logic                  push_req, push, pop, drop;

  always_comb begin
    byte_ok  = rx_valid & ~rx_ferr;
    byte_bad = rx_valid & rx_ferr;
    // A mode change abandons any partially packed word.
    idx_base = (mode != mode_q) ? '0 : idx_q;

    word_cur = part_q;
    for (int unsigned b = 0; b < WB; b++) begin
      if (BIG_ENDIAN ? (IDX_W'(WB - 1 - b) == idx_base) : (IDX_W'(b) == idx_base)) begin
        word_cur[b*8 +: 8] = rx_data;
      end
    end

    push_req  = 1'b0;
    push_word = DATA_W'(rx_data);
    idx_d     = idx_base;
    part_d    = part_q;
    if (mode) begin
      push_word = word_cur;
      if (byte_ok) begin
        part_d   = word_cur;
        push_req = (idx_base == LAST_IDX);
        idx_d    = (idx_base == LAST_IDX) ? '0 : idx_base + 1'b1;
      end
    end else begin
      push_req = byte_ok;
    end

    pop  = rd_req && (count_q != '0) && !rd_valid_q;
    push = push_req && ((count_q != DEPTH) || pop);
    drop = push_req && !push;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    overflow_d = flag_clr ? 1'b0 : (overflow_q | drop);
    ferr_d     = flag_clr ? 1'b0 : (ferr_q | byte_bad);
  end

  // Storage array carries no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      part_q     <= '0;
      idx_q      <= '0;
      mode_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      part_q     <= part_d;
      idx_q      <= idx_d;
      mode_q     <= mode;
      rd_valid_q <= pop;
      overflow_q <= overflow_d;
      ferr_q     <= ferr_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_data_q <= mem[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign ferr_seen = ferr_q;

endmodule

// File: tb/tb_uart_in_fifo.sv
// Directed bench for uart_in_fifo: two 4-deep instances (big- and little-endian packing)
// share all inputs; expected values are hand-computed constants.
module tb_uart_in_fifo;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ferr;
  logic        mode;
  logic        rd_req;
  logic        flag_clr;

  logic [31:0] rd_data_be, rd_data_le;
  logic        rd_valid_be, rd_valid_le;
  logic [2:0]  count_be, count_le;
  logic        overflow_be, overflow_le;
  logic        ferr_be, ferr_le;

  int checks = 0;
  int errors = 0;

  uart_in_fifo #(
    .DATA_W     (32),
    .DEPTH_LOG2 (2),
    .BIG_ENDIAN (1'b1)
  ) u_dut_be (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ferr   (rx_ferr),
    .mode      (mode),
    .rd_req    (rd_req),
    .rd_data   (rd_data_be),
    .rd_valid  (rd_valid_be),
    .count     (count_be),
    .overflow  (overflow_be),
    .ferr_seen (ferr_be),
    .flag_clr  (flag_clr)
  );

  uart_in_fifo #(
    .DATA_W     (32),
    .DEPTH_LOG2 (2),
    .BIG_ENDIAN (1'b0)
  ) u_dut_le (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ferr   (rx_ferr),
    .mode      (mode),
    .rd_req    (rd_req),
    .rd_data   (rd_data_le),
    .rd_valid  (rd_valid_le),
    .count     (count_le),
    .overflow  (overflow_le),
    .ferr_seen (ferr_le),
    .flag_clr  (flag_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic send(input logic [7:0] b, input logic ferr);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_ferr  = ferr;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp_data,
                           input logic [2:0] exp_cnt);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check({tag, "_valid"}, rd_valid_be, 1);
    check({tag, "_data"}, rd_data_be, exp_data);
    check({tag, "_count"}, count_be, exp_cnt);
    @(negedge clk);
    check({tag, "_pulse"}, rd_valid_be, 0);
  endtask

  initial begin
    int          pulses;
    logic [31:0] seen;

    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    mode     = 1'b0;
    rd_req   = 1'b0;
    flag_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data", rd_data_be, 0);
    check("rst_valid", rd_valid_be, 0);
    check("rst_count", count_be, 0);
    check("rst_ovf", overflow_be, 0);
    check("rst_ferr", ferr_be, 0);
    rst = 1'b0;
    @(negedge clk);

    // Byte mode: zero-extended bytes, one-cycle rd_valid.
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    check("byte_count2", count_be, 2);
    pop_check("byte_pop0", 32'h0000_0041, 3'd1);
    pop_check("byte_pop1", 32'h0000_0042, 3'd0);

    // Word mode packing in both byte orders.
    mode = 1'b1;
    @(negedge clk);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    check("word_partial_cnt", count_be, 0);
    send(8'h78, 1'b0);
    check("word_cnt", count_be, 1);
    pop_check("word_be", 32'h1234_5678, 3'd0);
    check("word_le", rd_data_le, 32'h7856_3412);

    // Overflow on a full 4-deep FIFO.
    mode = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    check("ovf_count", count_be, 4);
    check("ovf_flag", overflow_be, 1);
    for (int i = 1; i <= 4; i++) pop_check("ovf_pop", 32'(i), 3'(4 - i));
    check("ovf_sticky", overflow_be, 1);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("ovf_clr", overflow_be, 0);

    // Full FIFO: simultaneous push and pop is accepted.
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b0);
    rx_data  = 8'h14;
    rx_valid = 1'b1;
    rd_req   = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rd_req   = 1'b0;
    check("full_pp_valid", rd_valid_be, 1);
    check("full_pp_data", rd_data_be, 32'h10);
    check("full_pp_count", count_be, 4);
    check("full_pp_ovf", overflow_be, 0);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) pop_check("full_drain", 32'h10 + 32'(i), 3'(4 - i));

    // Pointer wrap over several fill/drain rounds.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) send(8'h20 + 8'(r * 16 + i), 1'b0);
      check("wrap_full", count_be, 4);
      for (int i = 0; i < 4; i++) pop_check("wrap_pop", 32'h20 + 32'(r * 16 + i), 3'(3 - i));
    end
    check("wrap_ovf", overflow_be, 0);

    // Mode toggle discards a partial word; framing-error byte is skipped.
    mode = 1'b1;
    @(negedge clk);
    send(8'hB0, 1'b0);
    send(8'hB1, 1'b0);
    mode = 1'b0;
    @(negedge clk);
    mode = 1'b1;
    @(negedge clk);
    send(8'hA0, 1'b0);
    send(8'hEE, 1'b1);
    check("ferr_set", ferr_be, 1);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    check("toggle_partial", count_be, 0);
    send(8'hA3, 1'b0);
    check("toggle_cnt", count_be, 1);
    pop_check("toggle_be", 32'hA0A1_A2A3, 3'd0);
    check("toggle_le", rd_data_le, 32'hA3A2_A1A0);

    // Clear wins over a same-cycle framing error.
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    rx_ferr  = 1'b1;
    flag_clr = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    flag_clr = 1'b0;
    check("ferr_clr_prio", ferr_be, 0);

    // Request held on an empty FIFO until a byte arrives.
    mode = 1'b0;
    @(negedge clk);
    rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("empty_wait", rd_valid_be, 0);
    end
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("late_cnt", count_be, 1);
    check("late_novalid", rd_valid_be, 0);
    pulses = 0;
    seen   = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_valid_be) begin
        pulses++;
        seen = rd_data_be;
      end
    end
    rd_req = 1'b0;
    check("late_pulses", 64'(pulses), 1);
    check("late_data", seen, 32'h55);
    check("late_empty", count_be, 0);

    // Asynchronous reset mid-word and mid-read.
    mode = 1'b1;
    @(negedge clk);
    send(8'hD0, 1'b0);
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b0);
    send(8'hE0, 1'b0);
    send(8'hE1, 1'b0);
    send(8'hFF, 1'b1);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("pre_rst_valid", rd_valid_be, 1);
    check("pre_rst_data", rd_data_be, 32'hD0D1_D2D3);
    #2 rst = 1'b1;
    #1;
    check("arst_data", rd_data_be, 0);
    check("arst_data_le", rd_data_le, 0);
    check("arst_valid", rd_valid_be, 0);
    check("arst_count", count_be, 0);
    check("arst_ferr", ferr_be, 0);
    check("arst_ovf", overflow_be, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'hC0, 1'b0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    check("post_rst_cnt", count_be, 1);
    pop_check("post_rst_word", 32'hC0C1_C2C3, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_in_fifo.md
Name: uart_in_fifo

Overview:
- Parametrised receive buffer between the byte-wide uart_rx and the datapath's IN instruction.
- Successor to the ALU's fixed 32-bit, zero-extended byte buffer.
- Adds word-packing mode, explicit occupancy count, a sticky overflow flag, framing-error filtering and a one-cycle read handshake.
- Sits beside the ALU; the ALU's IN path drives rd_req and consumes rd_data/rd_valid.

Parameters:
DATA_W, 32, output word width; multiple of 8, at least 8; WB = DATA_W/8 bytes per word.
DEPTH_LOG2, 14, FIFO holds 2**DEPTH_LOG2 words.
BIG_ENDIAN, 1, word mode only; 1 = first received byte lands in the MSBs, 0 = first byte lands in the LSBs.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
rx_data  input  8  byte from uart_rx.
rx_valid  input  1  one-cycle strobe; rx_data valid.
rx_ferr  input  1  framing error qualifying rx_valid.
mode  input  1  0 = byte mode (zero-extend each byte), 1 = word mode (pack WB bytes).
rd_req  input  1  level request from IN instruction.
rd_data  output  DATA_W  popped word; held until the next pop.
rd_valid  output  1  one-cycle pulse; rd_data is the newly popped word.
count  output  DEPTH_LOG2+1  words currently stored, 0..2**DEPTH_LOG2.
overflow  output  1  sticky; a complete word was dropped because the FIFO was full.
ferr_seen  output  1  sticky; at least one byte was discarded for a framing error.
flag_clr  input  1  clears overflow and ferr_seen (single cycle).

Behaviour:
- Reset (async assert, any state):
  - wr_ptr, rd_ptr and count go to 0.
  - The partial-word register and its byte index go to 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, ferr_seen = 0.
  - Mid-packing or mid-read state is discarded.
- Byte accept:
  - rx_valid=1 with rx_ferr=1: byte discarded, ferr_seen<=1, byte index unchanged.
  - rx_valid=1 with rx_ferr=0: byte accepted.
- Byte mode:
  - Each accepted byte forms word {(DATA_W-8)'b0, rx_data}, pushed the same cycle.
  - Store to memory is visible at the head one cycle later.
- Word mode:
  - Accepted bytes fill the partial register at byte index 0..WB-1, placed per BIG_ENDIAN.
  - On the WB-th byte, the completed word, including the current byte, is pushed that cycle and the index returns to 0.
  - Bytes not yet written in the partial register are don't-care; it is fully overwritten before every push.
- Mode change: any cycle where mode differs from its registered value clears the byte index. The partial word is discarded silently and no flag is set.
- Push rule: the push is accepted if count < 2**DEPTH_LOG2, or if a pop occurs the same cycle. Otherwise the word is dropped, overflow<=1 and the pointers are unchanged.
- Pop handshake:
  - A pop occurs when rd_req=1, count>0 and rd_valid=0 (registered value).
  - Next cycle: rd_data=mem[rd_ptr], rd_valid=1, rd_ptr+1.
  - rd_valid is high for exactly one cycle. With rd_req held high, pops occur on alternate cycles, so at most one word per 2 cycles.
  - Empty with rd_req=1: no pop, rd_valid stays 0, and the request waits until a word arrives. First pop is in the cycle the count becomes non-zero; rd_valid follows the next cycle.
- Count:
  - push-only: +1; pop-only: -1; push and pop together: unchanged.
  - Pointers are DEPTH_LOG2 bits and wrap modulo 2**DEPTH_LOG2.
  - count is registered and reflects completed pushes/pops.
- Flags: flag_clr takes priority over a same-cycle set.
- Memory: a simple dual-port array with synchronous write and synchronous read; rd_data is taken from the registered read.

Test Plan:
- Byte mode, DATA_W=32: bytes 0x41,0x42, then rd_req pulses -> rd_data 0x00000041 then 0x00000042, each rd_valid a single cycle; count 2->1->0.
- Word mode, BIG_ENDIAN=1: bytes 0x12,0x34,0x56,0x78 -> count 1 after the 4th byte; pop gives 0x12345678. Same stimulus with BIG_ENDIAN=0 gives 0x78563412.
- DEPTH_LOG2=2, byte mode: push 5 bytes 0x01..0x05 -> count 4, overflow=1, pops return 0x01..0x04; flag_clr -> overflow=0.
- Full FIFO with a push and a pop in the same cycle -> push accepted, count stays 4, overflow stays 0; ptr wrap verified over 3 fill/drain rounds.
- Word mode: 2 bytes, then mode toggled to 0 and back to 1, then 4 bytes 0xA0..0xA3 -> exactly one word, 0xA0A1A2A3. A byte sent with rx_ferr=1 sets ferr_seen and is not counted toward the word.
- rd_req held high on an empty FIFO for 10 cycles, then one byte 0x55 -> rd_valid pulses once with 0x00000055 and no second rd_valid. Assert rst mid-word and mid-read -> all outputs return to 0 immediately, count=0.
